// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising four cores onto one single-port shared mailbox bank.
// Latency: request sampled at edge t, access in cycle t+1, one-cycle ack in cycle t+2.
// Backpressure: requests are only sampled in IDLE; requesters hold req/we/addr/wdata until acked.
module shared_mem_arbiter #(
   parameter logic [31:0] SHARED_BASE = 32'h0000_1000,
   parameter int          DEPTH_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   core_req,
   input  logic [3:0]   core_we,
   input  logic [127:0] core_addr,
   input  logic [127:0] core_wdata,
   output logic [3:0]   core_ack,
   output logic [3:0]   core_err,
   output logic [31:0]  rdata,
   output logic         busy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    rr_ptr;
   logic [1:0]    idx;
   logic [1:0]    gnt_idx;
   logic [1:0]    cand;
   logic          gnt_vld;
   logic          we_q;
   logic          err_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          in_window;
   logic [AW-1:0] widx;
   logic          unused_addr_lsb;

   // Bank contents are deliberately not reset.
   logic [31:0]   bank [DEPTH_WORDS];

   // Word index and window decode of the latched address; byte offset is ignored.
   assign widx            = addr_q[AW+1:2];
   assign in_window       = (addr_q[31:10] == SHARED_BASE[31:10]);
   assign unused_addr_lsb = ^addr_q[1:0];

   // Round-robin search: the first requester at or after rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_ptr;
      cand    = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr + 2'(k);
         if (core_req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs; ack/err are decoded from state so reset clears them at once.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      core_ack  = 4'b0000;
      core_err  = 4'b0000;
      case (state)
         IDLE: begin
            if (gnt_vld) state_nxt = ACCESS;
         end
         ACCESS: begin
            busy      = 1'b1;
            state_nxt = ACK;
         end
         ACK: begin
            busy      = 1'b1;
            core_ack  = 4'b0001 << idx;
            core_err  = err_q ? (4'b0001 << idx) : 4'b0000;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the granted request, perform the read/decode, and advance the priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= 2'd0;
         idx     <= 2'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  idx     <= gnt_idx;
                  we_q    <= core_we[gnt_idx];
                  addr_q  <= core_addr[{gnt_idx, 5'b00000} +: 32];
                  wdata_q <= core_wdata[{gnt_idx, 5'b00000} +: 32];
               end
            end
            ACCESS: begin
               err_q <= !in_window;
               rdata <= (in_window && !we_q) ? bank[widx] : 32'd0;
            end
            ACK: begin
               rr_ptr <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Bank write on the ACCESS exit edge; a reset before that edge leaves state in IDLE and drops it.
   always_ff @(posedge clk) begin
      if (state == ACCESS && in_window && we_q) bank[widx] <= wdata_q;
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios plus randomized traffic.
// A transaction-level model predicts ack timing, err, busy and rdata every cycle.
// Requesters hold their request until acked, as a well-behaved core would.
module tb_shared_mem_arbiter;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   core_req = 4'b0;
   logic [3:0]   core_we = 4'b0;
   logic [127:0] core_addr = '0;
   logic [127:0] core_wdata = '0;
   logic [3:0]   core_ack;
   logic [3:0]   core_err;
   logic [31:0]  rdata;
   logic         busy;

   int checks = 0;
   int failures = 0;

   shared_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
      .core_err(core_err), .rdata(rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit in_win(logic [31:0] a);
      return a[31:10] == BASE[31:10];
   endfunction

   function automatic int oh2i(logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // ---------------- transaction-level model ----------------
   // ecnt counts rising edges out of reset; g_edge is the edge that granted the current access.
   int          ecnt = 0;
   int          g_edge = -100;
   int          m_rr = 0;
   int          g_idx = 0;
   bit          g_we, g_err;
   logic [31:0] g_addr, g_wdata;
   bit          exp_known = 0;
   logic [31:0] exp_rd = 0;
   logic [31:0] mem [int];

   always @(negedge rst_n) begin
      g_edge = -100;
      m_rr   = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         ecnt++;
         // Access completes one edge after the grant: commit writes, predict read data.
         if (ecnt == g_edge + 1) begin
            exp_known = 1;
            exp_rd    = 32'd0;
            if (!g_err && g_we) mem[int'(g_addr[9:2])] = g_wdata;
            else if (!g_err && !g_we) begin
               if (mem.exists(int'(g_addr[9:2]))) exp_rd = mem[int'(g_addr[9:2])];
               else exp_known = 0;
            end
         end
         // A new grant is possible three edges after the previous one.
         if (ecnt >= g_edge + 3 && core_req != 4'b0) begin
            bit found;
            found = 0;
            for (int k = 0; k < 4; k++) begin
               if (!found && core_req[(m_rr + k) % 4]) begin
                  found = 1;
                  g_idx = (m_rr + k) % 4;
               end
            end
            g_edge  = ecnt;
            g_we    = core_we[g_idx];
            g_addr  = core_addr[g_idx*32 +: 32];
            g_wdata = core_wdata[g_idx*32 +: 32];
            g_err   = !in_win(g_addr);
            m_rr    = (g_idx + 1) % 4;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      logic [3:0] ea, ee;
      bit         eb;
      if (!rst_n) begin
         chk("rst_ack", core_ack, 4'b0);
         chk("rst_err", core_err, 4'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_rdata", rdata, 32'd0);
      end else begin
         ea = (ecnt == g_edge + 1) ? (4'b0001 << g_idx) : 4'b0000;
         ee = (ecnt == g_edge + 1 && g_err) ? (4'b0001 << g_idx) : 4'b0000;
         eb = (ecnt == g_edge) || (ecnt == g_edge + 1);
         chk("ack", core_ack, ea);
         chk("err", core_err, ee);
         chk("busy", busy, eb);
         if (ea != 0 && exp_known) chk("rdata", rdata, exp_rd);
      end
   end

   // ---------------- directed helpers ----------------
   logic [3:0]  b_we;
   logic [31:0] b_addr [4];
   logic [31:0] b_wdata [4];
   logic [31:0] b_rd [4];
   logic [3:0]  b_err;
   int          b_lat [4];

   task automatic run_batch(input logic [3:0] mask);
      logic [3:0] pend;
      int         cyc;
      pend = mask;
      cyc  = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            core_we[i]             = b_we[i];
            core_addr[i*32 +: 32]  = b_addr[i];
            core_wdata[i*32 +: 32] = b_wdata[i];
            b_lat[i]               = -1;
         end
      end
      core_req = core_req | mask;
      while (pend != 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (pend[i] && core_ack[i]) begin
               b_rd[i]     = rdata;
               b_err[i]    = core_err[i];
               b_lat[i]    = cyc;
               pend[i]     = 1'b0;
               core_req[i] = 1'b0;
            end
         end
      end
      chk("batch_timeout", pend, 4'b0);
      core_req = core_req & ~pend;
   endtask

   task automatic one(input int c, input bit we, input logic [31:0] a, input logic [31:0] d);
      b_we[c]    = we;
      b_addr[c]  = a;
      b_wdata[c] = d;
      run_batch(4'b0001 << c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      int n, cyc, c0_at, c0_wait, c0_start, c0_lat;
      bit c0_up;
      int start [4];

      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_ack", core_ack, 4'b0);
      chk("post_rst_rdata", rdata, 32'd0);

      // Single write then read by core 2.
      one(2, 1, 32'h0000_1004, 32'hDEAD_BEEF);
      chk("wr_lat", b_lat[2], 2);
      chk("wr_err", b_err[2], 0);
      chk("wr_rdata", b_rd[2], 32'd0);
      one(2, 0, 32'h0000_1004, 32'd0);
      chk("rd_lat", b_lat[2], 2);
      chk("rd_data", b_rd[2], 32'hDEAD_BEEF);

      // Read-after-write race: rr_ptr is now 3, so core 3's write goes first.
      b_we[3] = 1; b_addr[3] = 32'h0000_10FC; b_wdata[3] = 32'h0000_0042;
      b_we[0] = 0; b_addr[0] = 32'h0000_10FC; b_wdata[0] = 32'd0;
      run_batch(4'b1001);
      chk("raw_lat3", b_lat[3], 2);
      chk("raw_lat0", b_lat[0], 5);
      chk("raw_data", b_rd[0], 32'h0000_0042);

      // All four read together after reset; includes unaligned addresses.
      do_reset();
      b_we = 4'b0000;
      b_addr[0] = 32'h0000_1004; b_addr[1] = 32'h0000_10FC;
      b_addr[2] = 32'h0000_1005; b_addr[3] = 32'h0000_10FE;
      run_batch(4'b1111);
      chk("all_lat0", b_lat[0], 2);
      chk("all_lat1", b_lat[1], 5);
      chk("all_lat2", b_lat[2], 8);
      chk("all_lat3", b_lat[3], 11);
      chk("all_rd0", b_rd[0], 32'hDEAD_BEEF);
      chk("all_rd1", b_rd[1], 32'h0000_0042);
      chk("all_rd2", b_rd[2], 32'hDEAD_BEEF);
      chk("all_rd3", b_rd[3], 32'h0000_0042);

      // Out-of-window write leaves the bank untouched.
      one(0, 1, 32'h0000_1008, 32'h0BAD_F00D);
      chk("oow_pre_err", b_err[0], 0);
      one(0, 1, 32'h0000_2008, 32'h1234_5678);
      chk("oow_err", b_err[0], 1);
      chk("oow_rdata", b_rd[0], 32'd0);
      one(0, 0, 32'h0000_1008, 32'd0);
      chk("oow_readback", b_rd[0], 32'h0BAD_F00D);

      // Reset during ACCESS drops the write and the ack.
      one(1, 1, 32'h0000_1010, 32'h0000_0000);
      @(negedge clk);
      core_we[1] = 1'b1;
      core_addr[32 +: 32] = 32'h0000_1010;
      core_wdata[32 +: 32] = 32'hA5A5_A5A5;
      core_req[1] = 1'b1;
      @(negedge clk);
      chk("abort_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy_now", busy, 1'b0);
      chk("abort_ack_now", core_ack, 4'b0);
      core_req = 4'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;
      n = 0;
      repeat (4) begin
         @(negedge clk);
         if (core_ack != 0) n++;
      end
      chk("abort_no_ack", n, 0);
      one(1, 0, 32'h0000_1010, 32'd0);
      chk("abort_reread", b_rd[1], 32'h0000_0000);

      // Fairness: cores 1 and 3 saturate, core 0 joins after four grants.
      do_reset();
      @(negedge clk);
      core_we = 4'b0000;
      core_addr[32 +: 32] = 32'h0000_1004;
      core_addr[96 +: 32] = 32'h0000_1008;
      core_addr[0 +: 32]  = 32'h0000_10FC;
      core_req = 4'b1010;
      n = 0; cyc = 0; c0_up = 0; c0_wait = -1; c0_at = 0; c0_start = 0; c0_lat = -1;
      while (n < 12 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (core_ack != 0) begin
            order.push_back(oh2i(core_ack));
            n++;
            if (core_ack[0]) begin
               core_req[0] = 1'b0;
               c0_wait = n - c0_at;
               c0_lat = cyc - c0_start;
            end
         end
         if (n == 4 && !c0_up) begin
            c0_up = 1;
            c0_at = n;
            c0_start = cyc;
            core_req[0] = 1'b1;
         end
      end
      core_req = 4'b0;
      chk("fair_count", n, 12);
      chk("fair_g0", order[0], 1);
      chk("fair_g1", order[1], 3);
      chk("fair_g2", order[2], 1);
      chk("fair_g3", order[3], 3);
      chk("fair_c0_within3", (c0_wait >= 1 && c0_wait <= 3), 1);
      chk("fair_c0_lat", (c0_lat >= 2 && c0_lat <= 11), 1);
      repeat (3) @(negedge clk);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 4; i++) start[i] = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (core_req[i] && core_ack[i]) begin
               chk("rand_lat_le11", (c - start[i]) <= 11, 1);
               core_req[i] = 1'b0;
            end else if (!core_req[i] && core_ack[i] == 1'b0 && $urandom_range(0, 3) == 0) begin
               logic [31:0] a;
               if ($urandom_range(0, 9) == 0) begin
                  a = $urandom;
                  if (in_win(a)) a[20] = ~a[20];
               end else begin
                  a = BASE + {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
               end
               core_we[i]             = 1'($urandom_range(0, 1));
               core_addr[i*32 +: 32]  = a;
               core_wdata[i*32 +: 32] = $urandom;
               core_req[i]            = 1'b1;
               start[i]               = c;
            end
         end
      end
      core_req = 4'b0;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
